// File: rtl/pixel_row_collector_pkg.sv
// Shared geometry, types and helpers for the pixel row collector.
package pixel_row_collector_pkg;

    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_ARRAY_HEIGHT = 4;
    localparam int OUTPUT_BUS_WIDTH   = 2;
    localparam int PIXEL_BITS         = 8;

    localparam int WORDS_PER_ROW = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int WC_W          = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int ROW_IDX_W     = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

    typedef logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_t;
    typedef logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  word_t;
    typedef logic [ROW_IDX_W-1:0]                         row_idx_t;
    typedef logic [WC_W-1:0]                              word_idx_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // True when the given row index is the last row of a frame.
    function automatic logic is_last_row(row_idx_t idx);
        return idx == row_idx_t'(PIXEL_ARRAY_HEIGHT - 1);
    endfunction

endpackage

// File: rtl/pixel_row_collector_if.sv
// Bus-word input stream and assembled-row output stream of the collector.
interface pixel_row_collector_if;
    import pixel_row_collector_pkg::*;

    logic     frame_start;
    logic     in_valid;
    word_t    in_data;
    row_t     row_data;
    row_idx_t row_index;
    logic     row_valid;
    logic     row_ready;
    logic     frame_end;
    logic     overflow;

    // Collector side.
    modport slave (
        input  frame_start, in_valid, in_data, row_ready,
        output row_data, row_index, row_valid, frame_end, overflow
    );

    // Environment side: word producer and row consumer.
    modport master (
        output frame_start, in_valid, in_data, row_ready,
        input  row_data, row_index, row_valid, frame_end, overflow
    );

endinterface

// File: rtl/pixel_row_collector_counter.sv
// Wrapping up-counter with a synchronous clear that takes effect before the
// increment of the same cycle, so a clear plus increment lands on 1.
module pixel_row_collector_counter #(
    parameter int WIDTH   = 1,
    parameter int MAX_VAL = 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_eff_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base;

    // Effective current value after clear, and the next value after increment.
    always_comb begin
        base    = clear_i ? '0 : count_q;
        wrap_o  = inc_i && (base == MAX_Q);
        count_d = base;
        if (inc_i) begin
            count_d = (base == MAX_Q) ? '0 : base + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign count_eff_o = base;

endmodule

// File: rtl/row_output_slot.sv
// One-entry valid/ready holding register for completed rows, with a sticky
// drop flag raised when a row arrives while the slot is full and not drained.
//
//   state      | meaning
//   SLOT_EMPTY | no row presented, valid_o low
//   SLOT_FULL  | row presented on data_o, waiting for ready_i
module row_output_slot
    import pixel_row_collector_pkg::*;
(
    input  logic     clk,
    input  logic     reset_i,
    input  logic     load_i,
    input  row_t     load_data_i,
    input  row_idx_t load_index_i,
    input  logic     load_last_i,
    input  logic     ready_i,
    output logic     valid_o,
    output row_t     data_o,
    output row_idx_t index_o,
    output logic     last_o,
    output logic     drop_o
);

    slot_state_e state_q;
    logic        valid_q;
    row_t        data_q;
    row_idx_t    index_q;
    logic        last_q;
    logic        drop_q;

    // Slot FSM; a draining consumer and a new row in the same cycle swap rows
    // without a bubble, otherwise the held row wins and the new one is dropped.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= SLOT_EMPTY;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (load_i) begin
                        state_q <= SLOT_FULL;
                        valid_q <= 1'b1;
                        data_q  <= load_data_i;
                        index_q <= load_index_i;
                        last_q  <= load_last_i;
                    end
                end
                SLOT_FULL: begin
                    if (load_i) begin
                        if (ready_i) begin
                            data_q  <= load_data_i;
                            index_q <= load_index_i;
                            last_q  <= load_last_i;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (ready_i) begin
                        state_q <= SLOT_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SLOT_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign index_o = index_q;
    assign last_o  = last_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/pixel_row_collector.sv
// Reassembles bus words into full pixel rows, tags them with a row index and
// end-of-frame flag, and presents them through a one-entry output slot.
module pixel_row_collector
    import pixel_row_collector_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pixel_row_collector_if.slave pix
);

    word_idx_t wc_cur;
    word_idx_t wc_eff;
    logic      row_done;
    row_idx_t  row_cur;
    row_idx_t  row_eff;
    logic      row_wrap;

    row_t      asm_q;
    row_t      asm_d;

    // Word position within the row; the wrap marks row completion.
    pixel_row_collector_counter #(
        .WIDTH   (WC_W),
        .MAX_VAL (WORDS_PER_ROW - 1)
    ) u_word_cnt (
        .clk         (clk),
        .reset_i     (reset),
        .clear_i     (pix.frame_start),
        .inc_i       (pix.in_valid),
        .count_o     (wc_cur),
        .count_eff_o (wc_eff),
        .wrap_o      (row_done)
    );

    // Row position within the frame; advances on every completion, dropped or not.
    pixel_row_collector_counter #(
        .WIDTH   (ROW_IDX_W),
        .MAX_VAL (PIXEL_ARRAY_HEIGHT - 1)
    ) u_row_cnt (
        .clk         (clk),
        .reset_i     (reset),
        .clear_i     (pix.frame_start),
        .inc_i       (row_done),
        .count_o     (row_cur),
        .count_eff_o (row_eff),
        .wrap_o      (row_wrap)
    );

    // Assembly buffer with the incoming word merged in; this merged value also
    // feeds the output slot so the final word needs no extra cycle.
    always_comb begin
        asm_d = pix.frame_start ? '0 : asm_q;
        if (pix.in_valid) begin
            for (int w = 0; w < WORDS_PER_ROW; w++) begin
                if (wc_eff == word_idx_t'(w)) begin
                    for (int p = 0; p < OUTPUT_BUS_WIDTH; p++) begin
                        asm_d[w*OUTPUT_BUS_WIDTH + p] = pix.in_data[p];
                    end
                end
            end
        end
    end

    // Assembly register.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

    row_output_slot u_slot (
        .clk          (clk),
        .reset_i      (reset),
        .load_i       (row_done),
        .load_data_i  (asm_d),
        .load_index_i (row_eff),
        .load_last_i  (is_last_row(row_eff)),
        .ready_i      (pix.row_ready),
        .valid_o      (pix.row_valid),
        .data_o       (pix.row_data),
        .index_o      (pix.row_index),
        .last_o       (pix.frame_end),
        .drop_o       (pix.overflow)
    );

endmodule

// File: tb/tb_pixel_row_collector.sv
// Directed bench for the pixel row collector.
module tb_pixel_row_collector;
    import pixel_row_collector_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    pixel_row_collector_if pif ();

    pixel_row_collector dut (
        .clk   (clk),
        .reset (reset),
        .pix   (pif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t mkw(input logic [7:0] a, input logic [7:0] b);
        word_t w;
        w[0] = a;
        w[1] = b;
        return w;
    endfunction

    function automatic row_t mkr(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d);
        row_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        pif.in_valid = 1'b1;
        pif.in_data  = mkw(a, b);
        step();
    endtask

    task automatic idle();
        pif.in_valid = 1'b0;
        pif.in_data  = '0;
    endtask

    task automatic chk_row(input string tag, input row_t d, input int idx, input logic fe);
        chk({tag, ".valid"}, 32'(pif.row_valid), 32'd1);
        chk({tag, ".data"},  32'(pif.row_data), 32'(d));
        chk({tag, ".index"}, 32'(pif.row_index), 32'(idx));
        chk({tag, ".fend"},  32'(pif.frame_end), 32'(fe));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(pif.row_valid), 32'd0);
        chk({tag, ".data"},  32'(pif.row_data), 32'd0);
        chk({tag, ".index"}, 32'(pif.row_index), 32'd0);
        chk({tag, ".fend"},  32'(pif.frame_end), 32'd0);
        chk({tag, ".ovf"},   32'(pif.overflow), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        pif.frame_start = 1'b0;
        pif.row_ready   = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        chk_zero("rst");

        // single row, one-cycle latency, drains next cycle
        send(8'h01, 8'h02);
        chk("t1.w0.valid", 32'(pif.row_valid), 32'd0);
        send(8'h03, 8'h04);
        chk_row("t1", mkr(8'h01, 8'h02, 8'h03, 8'h04), 0, 1'b0);
        idle();
        step();
        chk("t1.drain", 32'(pif.row_valid), 32'd0);

        // full frame plus one row, continuous words, index wraps
        pif.frame_start = 1'b1;
        step();
        pif.frame_start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            send(8'(4*r + 1), 8'(4*r + 2));
            chk($sformatf("t2.r%0d.w0", r), 32'(pif.row_valid), 32'd0);
            send(8'(4*r + 3), 8'(4*r + 4));
            chk_row($sformatf("t2.r%0d", r),
                    mkr(8'(4*r + 1), 8'(4*r + 2), 8'(4*r + 3), 8'(4*r + 4)),
                    r % 4, (r == 3));
        end
        idle();

        // stalled consumer: second row dropped, overflow sticky
        pif.frame_start = 1'b1;
        step();
        pif.frame_start = 1'b0;
        pif.row_ready   = 1'b0;
        send(8'hA1, 8'hA2);
        send(8'hA3, 8'hA4);
        chk_row("t3.a", mkr(8'hA1, 8'hA2, 8'hA3, 8'hA4), 0, 1'b0);
        chk("t3.a.ovf", 32'(pif.overflow), 32'd0);
        send(8'hB1, 8'hB2);
        chk("t3.b0.ovf", 32'(pif.overflow), 32'd0);
        send(8'hB3, 8'hB4);
        chk_row("t3.hold", mkr(8'hA1, 8'hA2, 8'hA3, 8'hA4), 0, 1'b0);
        chk("t3.ovf", 32'(pif.overflow), 32'd1);
        idle();
        pif.row_ready = 1'b1;
        step();
        chk("t3.drain", 32'(pif.row_valid), 32'd0);
        send(8'hC1, 8'hC2);
        send(8'hC3, 8'hC4);
        chk_row("t3.c", mkr(8'hC1, 8'hC2, 8'hC3, 8'hC4), 2, 1'b0);
        chk("t3.c.ovf", 32'(pif.overflow), 32'd1);
        idle();

        // frame_start discards a partial row and restarts the row count
        reset = 1'b1;
        step();
        reset = 1'b0;
        send(8'hD1, 8'hD2);
        send(8'hD3, 8'hD4);
        chk_row("t4.d", mkr(8'hD1, 8'hD2, 8'hD3, 8'hD4), 0, 1'b0);
        send(8'hAA, 8'hBB);
        idle();
        pif.frame_start = 1'b1;
        step();
        pif.frame_start = 1'b0;
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        chk_row("t4", mkr(8'h11, 8'h22, 8'h33, 8'h44), 0, 1'b0);
        chk("t4.ovf", 32'(pif.overflow), 32'd0);

        // frame_start coincident with a word: that word is word 0 of row 0
        pif.frame_start = 1'b1;
        send(8'h55, 8'h66);
        pif.frame_start = 1'b0;
        send(8'h77, 8'h88);
        chk_row("t5", mkr(8'h55, 8'h66, 8'h77, 8'h88), 0, 1'b0);
        idle();
        step();

        // reset with a row pending and overflow set clears everything
        pif.row_ready = 1'b0;
        send(8'hE1, 8'hE2);
        send(8'hE3, 8'hE4);
        send(8'hF1, 8'hF2);
        send(8'hF3, 8'hF4);
        chk_row("t6.pend", mkr(8'hE1, 8'hE2, 8'hE3, 8'hE4), 1, 1'b0);
        chk("t6.pend.ovf", 32'(pif.overflow), 32'd1);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero("t6.rst");
        pif.row_ready = 1'b1;
        send(8'h91, 8'h92);
        send(8'h93, 8'h94);
        chk_row("t6.g", mkr(8'h91, 8'h92, 8'h93, 8'h94), 0, 1'b0);
        chk("t6.g.ovf", 32'(pif.overflow), 32'd0);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
